// File: rtl/fm_mix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fm_mix_sequencer
// Brief    : Sample-rate operator sequencer and saturating stereo mixer for
//            the FM audio path. Each sample period it walks every operator
//            slot, issues select/advance strobes, accumulates attenuated
//            operator results into left/right sums and publishes them.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module fm_mix_sequencer #(
    parameter int OP_BITS    = 6,
    parameter int SAMPLE_DIV = 506,
    parameter int RES_W      = 13,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [OP_BITS-1:0]      op_sel,
    output logic                    op_next,
    output logic                    op_first,
    input  logic signed [RES_W-1:0] op_result,
    input  logic                    op_sum,
    input  logic                    op_l_en,
    input  logic                    op_r_en,
    input  logic [2:0]              op_atten,
    input  logic                    bus_wren,
    output logic                    bus_wait,
    input  logic                    clr_overrun,
    output logic [OUT_W-1:0]        audio_l,
    output logic [OUT_W-1:0]        audio_r,
    output logic                    sample_valid,
    output logic                    overrun
);

    localparam int NUM_OPS = 1 << OP_BITS;
    localparam int ACC_W   = RES_W + OP_BITS;
    localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [OP_BITS-1:0] LAST_OP  = OP_BITS'(NUM_OPS - 1);

    // Output range expressed at accumulator width for the saturation compare
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PROC  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q;
    logic                      tick_q;
    logic [OP_BITS-1:0]        op_sel_q, op_sel_d;
    logic                      op_next_q, op_next_d;
    logic                      op_first_q, op_first_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
    logic [OUT_W-1:0]          audio_l_q, audio_l_d;
    logic [OUT_W-1:0]          audio_r_q, audio_r_d;
    logic                      sample_valid_q, sample_valid_d;
    logic                      overrun_q, overrun_d;

    logic signed [RES_W-1:0]   w_shifted;
    logic signed [ACC_W-1:0]   w_addend;

    // Arithmetic shift floors toward minus infinity, then sign-extend
    assign w_shifted = op_result >>> op_atten;
    assign w_addend  = {{OP_BITS{w_shifted[RES_W-1]}}, w_shifted};

    function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (a < SAT_MIN)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return a[OUT_W-1:0];
    endfunction

    // Free-running sample divider; tick is a registered pulse on the wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            tick_q <= (div_q == DIV_LAST);
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_sel_q       <= '0;
            op_next_q      <= 1'b0;
            op_first_q     <= 1'b1;
            acc_l_q        <= '0;
            acc_r_q        <= '0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_sel_q       <= op_sel_d;
            op_next_q      <= op_next_d;
            op_first_q     <= op_first_d;
            acc_l_q        <= acc_l_d;
            acc_r_q        <= acc_r_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    // Next-state logic: slot walk, accumulation, publish and overrun tracking
    always_comb begin
        state_d        = state_q;
        op_sel_d       = op_sel_q;
        op_first_d     = op_first_q;
        acc_l_d        = acc_l_q;
        acc_r_d        = acc_r_q;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        sample_valid_d = 1'b0;
        // Advance strobe lands in the cycle after each slot is processed
        op_next_d      = (state_q == S_PROC);

        // A collision outranks a clear in the same cycle
        overrun_d = overrun_q;
        if (clr_overrun)
            overrun_d = 1'b0;
        if (tick_q && (state_q != S_IDLE))
            overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    if (enable)
                        state_d = S_START;
                    else
                        op_first_d = 1'b1;
                end
            end
            S_START: begin
                op_sel_d = '0;
                state_d  = S_PROC;
            end
            S_PROC: begin
                if (!op_first_q && op_sum) begin
                    if (op_l_en)
                        acc_l_d = acc_l_q + w_addend;
                    if (op_r_en)
                        acc_r_d = acc_r_q + w_addend;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (op_sel_q == LAST_OP) begin
                    state_d = S_DONE;
                end else begin
                    op_sel_d = op_sel_q + OP_BITS'(1);
                    state_d  = S_PROC;
                end
            end
            S_DONE: begin
                audio_l_d      = sat(acc_l_q);
                audio_r_d      = sat(acc_r_q);
                sample_valid_d = 1'b1;
                acc_l_d        = '0;
                acc_r_d        = '0;
                op_first_d     = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign op_sel       = op_sel_q;
    assign op_next      = op_next_q;
    assign op_first     = op_first_q;
    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    // Host writes are held off for the whole walk
    assign bus_wait     = bus_wren && (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fm_mix_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_mix_sequencer
// Brief    : Directed self-checking bench for fm_mix_sequencer. A default
//            instance (divider 506) covers mixing, saturation, attenuation,
//            timing and reset; a second instance (divider 100) covers overrun.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_mix_sequencer;

    localparam int OP_BITS = 6;
    localparam int RES_W   = 13;
    localparam int OUT_W   = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    enable = 1'b1;
    logic signed [RES_W-1:0] op_result = 13'd100;
    logic                    op_sum = 1'b1;
    logic                    op_l_en = 1'b1;
    logic                    op_r_en = 1'b0;
    logic [2:0]              op_atten = 3'd0;
    logic                    bus_wren = 1'b1;
    logic                    clr_overrun = 1'b0;

    logic [OP_BITS-1:0] op_sel, ov_op_sel;
    logic               op_next, ov_op_next;
    logic               op_first, ov_op_first;
    logic               bus_wait, ov_bus_wait;
    logic [OUT_W-1:0]   audio_l, audio_r, ov_audio_l, ov_audio_r;
    logic               sample_valid, ov_sample_valid;
    logic               overrun, ov_overrun;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fm_mix_sequencer #(.OP_BITS(OP_BITS), .SAMPLE_DIV(506), .RES_W(RES_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .op_sel(op_sel), .op_next(op_next), .op_first(op_first),
        .op_result(op_result), .op_sum(op_sum), .op_l_en(op_l_en), .op_r_en(op_r_en),
        .op_atten(op_atten), .bus_wren(bus_wren), .bus_wait(bus_wait),
        .clr_overrun(clr_overrun), .audio_l(audio_l), .audio_r(audio_r),
        .sample_valid(sample_valid), .overrun(overrun)
    );

    fm_mix_sequencer #(.OP_BITS(OP_BITS), .SAMPLE_DIV(100), .RES_W(RES_W), .OUT_W(OUT_W)) dut_ov (
        .clk(clk), .reset(reset), .enable(enable),
        .op_sel(ov_op_sel), .op_next(ov_op_next), .op_first(ov_op_first),
        .op_result(op_result), .op_sum(op_sum), .op_l_en(op_l_en), .op_r_en(op_r_en),
        .op_atten(op_atten), .bus_wren(bus_wren), .bus_wait(ov_bus_wait),
        .clr_overrun(clr_overrun), .audio_l(ov_audio_l), .audio_r(ov_audio_r),
        .sample_valid(ov_sample_valid), .overrun(ov_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Steps one cycle at a time until the chosen instance pulses sample_valid.
    // For the main instance it counts op_next pulses and the cycles from the
    // first bus_wait high (START, one cycle after the tick) to sample_valid.
    task automatic wait_valid(input bit ov, input int limit,
                              output int nexts, output int rise_to_valid);
        int rise;
        rise = -1;
        nexts = 0;
        rise_to_valid = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (ov) begin
                if (ov_sample_valid) return;
            end else begin
                if (op_next) nexts++;
                if (bus_wait && rise < 0) rise = i;
                if (sample_valid) begin
                    if (rise >= 0) rise_to_valid = i - rise;
                    return;
                end
            end
        end
        timeout(ov ? "ov_wait_valid" : "wait_valid");
    endtask

    initial begin
        int  n, r, vcnt, bcnt;
        bit  found;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio_l", 32'(audio_l), 32'h0);
        check("rst_audio_r", 32'(audio_r), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_op_sel", 32'(op_sel), 32'h0);
        check("rst_op_next", 32'(op_next), 32'h0);
        check("rst_op_first", 32'(op_first), 32'h1);
        check("rst_bus_wait", 32'(bus_wait), 32'h0);
        @(negedge clk) reset = 1'b0;

        // ---------------- overrun on the fast-divider instance ----------------
        wait_valid(1'b1, 400, n, r);
        check("ov_first_audio_l", 32'(ov_audio_l), 32'h0);
        check("ov_overrun_set", 32'(ov_overrun), 32'h1);
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        check("ov_overrun_clr", 32'(ov_overrun), 32'h0);
        check("ov_bus_wait_idle", 32'(ov_bus_wait), 32'h0);
        wait_valid(1'b1, 400, n, r);
        check("ov_overrun_again", 32'(ov_overrun), 32'h1);
        check("ov_audio_l_6400", 32'(ov_audio_l), 32'd6400);

        // ---------------- first walk publishes 0/0 ----------------
        wait_valid(1'b0, 1200, n, r);
        check("w1_audio_l", 32'(audio_l), 32'h0);
        check("w1_audio_r", 32'(audio_r), 32'h0);
        check("w1_op_next_cnt", 32'(n), 32'd64);
        check("w1_tick_to_valid", 32'(r + 1), 32'd131);
        check("w1_op_first_clr", 32'(op_first), 32'h0);
        check("w1_bus_wait_idle", 32'(bus_wait), 32'h0);
        check("w1_no_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        check("w1_valid_one_cycle", 32'(sample_valid), 32'h0);

        // ---------------- 100 x 64 to left only ----------------
        wait_valid(1'b0, 1200, n, r);
        check("w2_audio_l", 32'(audio_l), 32'd6400);
        check("w2_audio_r", 32'(audio_r), 32'h0);
        check("w2_op_next_cnt", 32'(n), 32'd64);

        // ---------------- positive saturation ----------------
        op_result = 13'd4095;
        op_r_en   = 1'b1;
        wait_valid(1'b0, 1200, n, r);
        check("sat_pos_l", 32'(audio_l), 32'h7FFF);
        check("sat_pos_r", 32'(audio_r), 32'h7FFF);

        // ---------------- negative saturation ----------------
        op_result = 13'h1000;   // -4096
        wait_valid(1'b0, 1200, n, r);
        check("sat_neg_l", 32'(audio_l), 32'h8000);
        check("sat_neg_r", 32'(audio_r), 32'h8000);

        // ---------------- floor attenuation: (-100 >>> 3) x 64 = -832 ----------------
        op_result = 13'h1F9C;   // -100
        op_atten  = 3'd3;
        wait_valid(1'b0, 1200, n, r);
        check("atten_l", 32'(audio_l), 32'hFCC0);
        check("atten_r", 32'(audio_r), 32'hFCC0);
        check("atten_no_overrun", 32'(overrun), 32'h0);

        // ---------------- asynchronous reset at slot 20 ----------------
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(posedge clk); #1;
            if (bus_wait && op_sel == 6'd20) found = 1'b1;
        end
        if (!found) timeout("slot20_wait");
        #1 reset = 1'b1;
        #1;
        check("mid_rst_audio_l", 32'(audio_l), 32'h0);
        check("mid_rst_audio_r", 32'(audio_r), 32'h0);
        check("mid_rst_op_first", 32'(op_first), 32'h1);
        check("mid_rst_op_sel", 32'(op_sel), 32'h0);
        check("mid_rst_op_next", 32'(op_next), 32'h0);
        check("mid_rst_bus_wait", 32'(bus_wait), 32'h0);
        enable = 1'b0;
        @(negedge clk) reset = 1'b0;

        // ---------------- enable low across a tick: no walk ----------------
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            if (sample_valid) vcnt++;
            if (bus_wait) bcnt++;
        end
        check("disabled_valid_cnt", 32'(vcnt), 32'd0);
        check("disabled_busy_cnt", 32'(bcnt), 32'd0);
        check("disabled_op_first", 32'(op_first), 32'h1);

        // ---------------- re-enable: first walk again publishes 0/0 ----------------
        enable = 1'b1;
        wait_valid(1'b0, 1200, n, r);
        check("reen_audio_l", 32'(audio_l), 32'h0);
        check("reen_audio_r", 32'(audio_r), 32'h0);

        // ---------------- enable dropped mid-walk: walk completes ----------------
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(posedge clk); #1;
            if (bus_wait) found = 1'b1;
        end
        if (!found) timeout("walk_start_wait");
        enable = 1'b0;
        wait_valid(1'b0, 400, n, r);
        check("en_drop_audio_l", 32'(audio_l), 32'hFCC0);
        check("en_drop_audio_r", 32'(audio_r), 32'hFCC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
